// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// No logic here: widths, the PC step and the queued {pc, instr} pair.
package fetch_pkg;
    localparam int XLEN    = 32;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;
endpackage

// File: rtl/fq_fifo.sv
// Generic synchronous FIFO with full/empty/count and synchronous clear.
// Latency: a push is visible at pop_data on the cycle after the write edge.
// Backpressure: pushes when full are dropped unless a pop frees the slot in the same cycle.
module fq_fifo #(
    parameter  int W  = 32,
    parameter  int D  = 4,
    localparam int AW = (D > 1) ? $clog2(D) : 1,
    localparam int CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [D];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(D - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(D));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    // Empty slots read as zero so downstream data is quiet when nothing is valid.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues in-order imem requests for the PC and queues {pc, instr} for decode.
// Latency: grant at N, response at N+1 earliest, dec_valid at N+2. Optional stall_cnt under FETCH_QUEUE_PERF_EN.
// Backpressure: requests are credit-limited by outstanding + occupancy vs DEPTH; decode uses valid/ready.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_addr,
    output logic            pc_advance,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);
    localparam int QCW = $clog2(DEPTH + 1);
    localparam int TCW = $clog2(MAX_OUT + 1);

    logic [TCW-1:0]  outstanding;
    logic [TCW-1:0]  discard_cnt;
    logic [QCW-1:0]  occupancy;
    logic [XLEN-1:0] trk_pc;
    logic            trk_empty;
    logic            trk_full;
    logic            q_empty;
    logic            q_full;
    logic            rsp;
    logic            q_push;
    logic            q_pop;
    fq_entry_t       q_in;
    fq_entry_t       q_out;

    assign imem_req   = rst_n && !flush && (32'(outstanding) < MAX_OUT)
                        && (32'(outstanding) + 32'(occupancy) < DEPTH);
    assign imem_addr  = rst_n ? pc_addr : '0;
    assign pc_advance = imem_req && imem_gnt;

    // A response with nothing tracked is a protocol error and is ignored.
    assign rsp    = imem_rvalid && !trk_empty;
    assign q_push = rsp && !flush && (discard_cnt == '0);
    assign q_pop  = dec_valid && dec_ready;
    assign q_in   = '{pc: trk_pc, instr: imem_rdata};

    assign dec_valid = rst_n && !q_empty;
    assign dec_instr = q_out.instr;
    assign dec_pc    = q_out.pc;

    fq_fifo #(.W(XLEN), .D(MAX_OUT)) u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (1'b0),
        .push      (pc_advance),
        .push_data (pc_addr),
        .pop       (rsp),
        .pop_data  (trk_pc),
        .full      (trk_full),
        .empty     (trk_empty),
        .count     (outstanding)
    );

    fq_fifo #(.W($bits(fq_entry_t)), .D(DEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .pop_data  (q_out),
        .full      (q_full),
        .empty     (q_empty),
        .count     (occupancy)
    );

    // On redirect every fetch still in flight after this cycle belongs to the old path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            discard_cnt <= '0;
        end else if (flush) begin
            discard_cnt <= outstanding - TCW'(rsp);
        end else if (rsp && (discard_cnt != '0)) begin
            discard_cnt <= discard_cnt - TCW'(1);
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (dec_ready && !dec_valid && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

    a_rsp_tracked: assert property (@(posedge clk) disable iff (!rst_n) imem_rvalid |-> !trk_empty);
    a_trk_room:    assert property (@(posedge clk) disable iff (!rst_n) pc_advance |-> !trk_full);
    a_q_room:      assert property (@(posedge clk) disable iff (!rst_n) q_push |-> (!q_full || q_pop));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, streaming, backpressure, flush and same-cycle events,
// plus the stall counter when FETCH_QUEUE_PERF_EN is defined.
module tb_fetch_queue;
    import fetch_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] pc_addr = '0;
    logic            pc_advance;
    logic            flush = 1'b0;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt = 1'b0;
    logic            imem_rvalid = 1'b0;
    logic [XLEN-1:0] imem_rdata = '0;
    logic            dec_valid;
    logic            dec_ready = 1'b0;
    logic [XLEN-1:0] dec_instr;
    logic [XLEN-1:0] dec_pc;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0]     stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .MAX_OUT(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_addr     (pc_addr),
        .pc_advance  (pc_advance),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dec(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, "_valid"}, 32'(dec_valid), 32'(v));
        chk({tag, "_pc"}, dec_pc, pc);
        chk({tag, "_instr"}, dec_instr, ins);
    endtask

    // One cycle out of reset: drive at the falling edge, settle, then the caller samples.
    task automatic cyc(input logic [31:0] pc, input logic fl, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic rdy);
        @(negedge clk);
        rst_n       = 1'b1;
        pc_addr     = pc;
        flush       = fl;
        imem_gnt    = gnt;
        imem_rvalid = rv;
        imem_rdata  = rd;
        dec_ready   = rdy;
        #1;
    endtask

    initial begin
        // Reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst_n       = 1'b0;
            pc_addr     = $urandom;
            flush       = 1'($urandom_range(0, 1));
            imem_gnt    = 1'($urandom_range(0, 1));
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            dec_ready   = 1'($urandom_range(0, 1));
            #1;
        end
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_adv", 32'(pc_advance), 32'd0);
        chk_dec("rst_dec", 1'b0, 32'h0, 32'h0);

        // Stream: four fetches, responses one cycle after grant.
        cyc(0 * PC_STEP, 0, 1, 0, 32'h0, 1);
        chk("s0_req", 32'(imem_req), 32'd1);
        chk("s0_adv", 32'(pc_advance), 32'd1);
        chk("s0_dv", 32'(dec_valid), 32'd0);
        cyc(1 * PC_STEP, 0, 1, 1, 32'h13, 1);
        chk("s1_adv", 32'(pc_advance), 32'd1);
        chk("s1_dv", 32'(dec_valid), 32'd0);
        cyc(2 * PC_STEP, 0, 1, 1, 32'h93, 1);
        chk_dec("s2", 1'b1, 32'h0, 32'h13);
        cyc(3 * PC_STEP, 0, 1, 1, 32'h113, 1);
        chk_dec("s3", 1'b1, 32'h4, 32'h93);
        cyc(4 * PC_STEP, 0, 0, 1, 32'h193, 1);
        chk_dec("s4", 1'b1, 32'h8, 32'h113);
        chk("s4_adv_nognt", 32'(pc_advance), 32'd0);
        cyc(32'h10, 0, 0, 0, 32'h0, 1);
        chk_dec("s5", 1'b1, 32'hC, 32'h193);
        cyc(32'h10, 0, 0, 0, 32'h0, 1);
        chk("s6_dv", 32'(dec_valid), 32'd0);

        // Backpressure: fill the queue with decode stalled, then drain.
        cyc(32'h20, 0, 1, 0, 32'h0, 0);
        chk("b0_adv", 32'(pc_advance), 32'd1);
        cyc(32'h24, 0, 1, 1, 32'hA0, 0);
        chk("b1_adv", 32'(pc_advance), 32'd1);
        cyc(32'h28, 0, 1, 1, 32'hA1, 0);
        cyc(32'h2C, 0, 1, 1, 32'hA2, 0);
        chk("b3_adv", 32'(pc_advance), 32'd1);
        chk_dec("b3", 1'b1, 32'h20, 32'hA0);
        cyc(32'h30, 0, 1, 1, 32'hA3, 0);
        chk("b4_req", 32'(imem_req), 32'd0);
        chk("b4_adv", 32'(pc_advance), 32'd0);
        cyc(32'h30, 0, 1, 0, 32'h0, 0);
        chk("b5_req", 32'(imem_req), 32'd0);
        chk("b5_adv", 32'(pc_advance), 32'd0);
        chk_dec("b5", 1'b1, 32'h20, 32'hA0);
        cyc(32'h30, 0, 1, 0, 32'h0, 1);
        chk("b6_req_full_pop", 32'(imem_req), 32'd0);
        chk_dec("b6", 1'b1, 32'h20, 32'hA0);
        cyc(32'h30, 0, 1, 0, 32'h0, 1);
        chk("b7_adv", 32'(pc_advance), 32'd1);
        chk_dec("b7", 1'b1, 32'h24, 32'hA1);
        cyc(32'h34, 0, 0, 1, 32'hA4, 1);
        chk_dec("b8", 1'b1, 32'h28, 32'hA2);
        cyc(32'h34, 0, 0, 0, 32'h0, 1);
        chk_dec("b9", 1'b1, 32'h2C, 32'hA3);
        cyc(32'h34, 0, 0, 0, 32'h0, 1);
        chk_dec("b10", 1'b1, 32'h30, 32'hA4);
        cyc(32'h34, 0, 0, 0, 32'h0, 1);
        chk("b11_dv", 32'(dec_valid), 32'd0);

        // Flush with two fetches outstanding.
        cyc(32'h40, 0, 1, 0, 32'h0, 1);
        chk("f0_adv", 32'(pc_advance), 32'd1);
        cyc(32'h44, 0, 1, 0, 32'h0, 1);
        chk("f1_adv", 32'(pc_advance), 32'd1);
        cyc(32'h48, 1, 1, 0, 32'h0, 1);
        chk("f2_req", 32'(imem_req), 32'd0);
        chk("f2_adv", 32'(pc_advance), 32'd0);
        cyc(32'h100, 0, 1, 1, 32'hDEAD, 1);
        chk("f3_adv", 32'(pc_advance), 32'd0);
        chk("f3_dv", 32'(dec_valid), 32'd0);
        cyc(32'h100, 0, 1, 1, 32'hBEEF, 1);
        chk("f4_adv", 32'(pc_advance), 32'd1);
        chk("f4_dv", 32'(dec_valid), 32'd0);
        cyc(32'h104, 0, 0, 1, 32'h1111, 1);
        chk("f5_dv", 32'(dec_valid), 32'd0);
        cyc(32'h104, 0, 0, 0, 32'h0, 1);
        chk_dec("f6", 1'b1, 32'h100, 32'h1111);

        // Response in the flush cycle, grant plus response in the same cycle.
        cyc(32'h200, 0, 1, 0, 32'h0, 1);
        chk("x0_adv", 32'(pc_advance), 32'd1);
        cyc(32'h204, 0, 1, 1, 32'h2000, 1);
        chk("x1_adv", 32'(pc_advance), 32'd1);
        cyc(32'h208, 1, 1, 1, 32'h2040, 1);
        chk("x2_req", 32'(imem_req), 32'd0);
        chk_dec("x2", 1'b1, 32'h200, 32'h2000);
        cyc(32'h300, 0, 1, 0, 32'h0, 1);
        chk("x3_dv", 32'(dec_valid), 32'd0);
        chk("x3_adv", 32'(pc_advance), 32'd1);
        cyc(32'h304, 0, 0, 1, 32'h3000, 1);
        chk("x4_dv", 32'(dec_valid), 32'd0);
        cyc(32'h304, 0, 0, 0, 32'h0, 1);
        chk_dec("x5", 1'b1, 32'h300, 32'h3000);

`ifdef FETCH_QUEUE_PERF_EN
        // Stall counter: fresh reset, then ten starved cycles with decode ready.
        @(negedge clk);
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        flush       = 1'b0;
        dec_ready   = 1'b0;
        #1;
        cyc(32'h400, 0, 0, 0, 32'h0, 1);
        chk("p_start", stall_cnt, 32'd0);
        for (int i = 1; i < 10; i++) cyc(32'h400, 0, 0, 0, 32'h0, 1);
        cyc(32'h400, 0, 0, 0, 32'h0, 0);
        chk("p_stall10", stall_cnt, 32'd10);
        cyc(32'h400, 0, 0, 0, 32'h0, 0);
        chk("p_hold", stall_cnt, 32'd10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage directly downstream of the program counter. Each cycle it takes the current PC, issues an in-order request to instruction memory, and pairs every returned word with its PC. It buffers the pairs in a small queue and presents them to decode over a valid/ready handshake. When PC advance must be held, it signals the PC, and it drops in-flight fetches on branch, refill or restart redirects.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- MAX_OUT, 2: maximum outstanding memory requests; 1..DEPTH
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- pc_addr  in  32  current PC value
- pc_advance  out  1  request accepted this cycle; PC may step to PC+4
- flush  in  1  redirect this cycle (branch, refill or restart)
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address; equals pc_addr
- imem_gnt  in  1  request accepted
- imem_rvalid  in  1  response valid; responses return in order
- imem_rdata  in  32  instruction word
- dec_valid  out  1  entry available to decode
- dec_ready  in  1  decode accepts entry
- dec_instr  out  32  instruction
- dec_pc  out  32  PC of dec_instr
- stall_cnt  out  32  cycles with dec_valid=0 and dec_ready=1 (FETCH_QUEUE_PERF_EN only)

## Operation
- Credit rule: imem_req = !flush && outstanding < MAX_OUT && (outstanding + occupancy) < DEPTH. The queue therefore never overflows.
- Request acceptance: imem_req && imem_gnt. On acceptance, pc_advance=1 and pc_addr is pushed into the PC tracker (depth MAX_OUT). outstanding increments.
- Response: imem_rvalid pops the tracker and decrements outstanding. If discard_cnt = 0, {tracker PC, imem_rdata} is pushed to the queue. If discard_cnt > 0, the response is dropped and discard_cnt decrements.
- Decode pop: dec_valid && dec_ready.
- Flush: the queue is emptied at the next edge. discard_cnt is loaded with the remaining outstanding count, which is outstanding minus any response arriving in the flush cycle. A response arriving in the flush cycle is also dropped. There is no request and no pc_advance in the flush cycle. A decode handshake in the flush cycle is still valid.
- Grant and response in the same cycle: outstanding is unchanged.
- imem_rvalid with outstanding=0 is a protocol violation. It is ignored and flagged by an assertion.
- Reset: queue, tracker, outstanding, discard_cnt and stall_cnt are cleared. All outputs are 0.

## Timing
- Grant at cycle N. Earliest rvalid is N+1. dec_valid rises at N+2, because queue output is registered.
- Sustained throughput is 1 instruction per cycle with gnt=1, rvalid one cycle after grant, and dec_ready=1.
- pc_advance is combinational from imem_gnt in the same cycle.
- dec_valid, dec_instr and dec_pc are stable while dec_valid=1 and dec_ready=0.
- Full queue with a pop in the same cycle: credit frees at the next edge, not combinationally.
- rst_n low mid-operation: in-flight responses after reset are not tracked. The memory side must be reset in the same cycle.

## Configuration
- FETCH_QUEUE_PERF_EN defined: stall_cnt is present. It increments by 1 on each cycle with dec_ready=1 and dec_valid=0, saturates at 0xFFFF_FFFF, and clears on reset.
- Macro undefined: the stall_cnt port and its counter are absent.

## Structure
- Package fetch_pkg holds:
  - typedef fq_entry_t {pc[31:0], instr[31:0]}
  - constant XLEN=32
  - constant PC_STEP=4
- Sub-module fq_fifo is a parameterised synchronous FIFO with registered output, full/empty flags and synchronous clear. It is instantiated twice: as the queue (fq_entry_t, DEPTH) and as the PC tracker (32-bit, MAX_OUT).

## Test plan
- Reset: hold rst_n=0 for 2 cycles with random inputs. Required: imem_req, pc_advance, dec_valid, dec_instr and dec_pc are all 0.
- Stream: pc steps 0x0/0x4/0x8/0xC, gnt=1, rvalid at N+1, rdata 0x13/0x93/0x113/0x193, dec_ready=1. Required: decode sees the four pairs in order, one per cycle, starting at cycle 2.
- Backpressure: dec_ready=0 while streaming. Required: after 4 entries imem_req=0 and pc_advance=0. Releasing dec_ready drains the queue in order and requests resume, with no loss or duplicates.
- Flush with 2 outstanding: flush, then pc_addr=0x100. Required: the next 2 responses are dropped. The first entry after flush has dec_pc=0x100.
- Simultaneous events: rvalid in the flush cycle, and grant plus rvalid in the same cycle. Required: the flush-cycle response is dropped and outstanding stays consistent (tracker assertion holds).
- FETCH_QUEUE_PERF_EN: dec_ready=1 with memory stalled (gnt=0) for 10 cycles. Required: stall_cnt=10.
